// File: rtl/dcache_axi_req_arb.sv
// rtl/dcache_axi_req_arb.sv - round-robin arbiter sharing one request FIFO between refill and writeback
module dcache_axi_req_arb #(
  parameter int ADDR_W = 2,
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              flush_i,
  input  logic              req0_valid_i,
  input  logic [DATA_W-1:0] req0_data_i,
  output logic              req0_accept_o,
  input  logic              req1_valid_i,
  input  logic [DATA_W-1:0] req1_data_i,
  output logic              req1_accept_o,
  output logic              out_valid_o,
  output logic [DATA_W-1:0] out_data_o,
  output logic              out_src_o,
  input  logic              out_accept_i,
  output logic [ADDR_W:0]   count_o,
  output logic              full_o,
  output logic              empty_o
);
  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              prio_q, prio_d;
  logic [DATA_W:0]   mem_q [DEPTH];
  logic [DATA_W:0]   head;
  logic              full, empty, can_push, gnt0, gnt1, push, pop;
  logic [DATA_W-1:0] push_data;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // Registered full only: a same-cycle pop never makes room for a push.
  assign can_push  = ~full & ~flush_i;
  assign gnt0      = can_push & req0_valid_i & (~req1_valid_i | ~prio_q);
  assign gnt1      = can_push & req1_valid_i & (~req0_valid_i | prio_q);
  assign push      = gnt0 | gnt1;
  assign push_data = gnt1 ? req1_data_i : req0_data_i;
  assign pop       = ~empty & out_accept_i & ~flush_i;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    prio_d   = prio_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      prio_d   = 1'b0;
    end else begin
      if (pop)  rd_ptr_d = rd_ptr_q + ADDR_W'(1);
      if (push) begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(1);
        prio_d   = gnt0;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + (ADDR_W+1)'(1);
        2'b01:   count_d = count_q - (ADDR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      prio_q   <= 1'b0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      prio_q   <= prio_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wr_ptr_q] <= {gnt1, push_data};
  end

  assign head          = mem_q[rd_ptr_q];
  assign out_data_o    = head[DATA_W-1:0];
  assign out_src_o     = head[DATA_W];
  assign out_valid_o   = ~empty;
  assign req0_accept_o = gnt0;
  assign req1_accept_o = gnt1;
  assign count_o       = count_q;
  assign full_o        = full;
  assign empty_o       = empty;
endmodule

// File: tb/tb_dcache_axi_req_arb.sv
// tb/tb_dcache_axi_req_arb.sv - randomized and directed checks of dcache_axi_req_arb against a queue model
module tb_dcache_axi_req_arb;
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        flush_i = 1'b0;
  logic        req0_valid_i = 1'b0, req1_valid_i = 1'b0, out_accept_i = 1'b0;
  logic [31:0] req0_data_i = '0, req1_data_i = '0;
  logic        req0_accept_o, req1_accept_o, out_valid_o, out_src_o, full_o, empty_o;
  logic [31:0] out_data_o;
  logic [2:0]  count_o;

  dcache_axi_req_arb #(.ADDR_W(2), .DATA_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
    .req0_valid_i(req0_valid_i), .req0_data_i(req0_data_i), .req0_accept_o(req0_accept_o),
    .req1_valid_i(req1_valid_i), .req1_data_i(req1_data_i), .req1_accept_o(req1_accept_o),
    .out_valid_o(out_valid_o), .out_data_o(out_data_o), .out_src_o(out_src_o),
    .out_accept_i(out_accept_i), .count_o(count_o), .full_o(full_o), .empty_o(empty_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: FIFO contents as {src, data} and which requester wins the next tie.
  logic [32:0] mq[$];
  logic        pref = 1'b0;
  logic        last_a0, last_a1;
  logic [31:0] popped[$];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    mq.delete();
    pref = 1'b0;
  endtask

  // Called at a negedge: drive, check combinational/state outputs, advance one edge.
  task automatic step(input logic v0, input logic [31:0] d0, input logic v1,
                      input logic [31:0] d1, input logic acc, input logic fl);
    logic full, g0, g1, do_pop;
    req0_valid_i = v0; req0_data_i = d0;
    req1_valid_i = v1; req1_data_i = d1;
    out_accept_i = acc; flush_i = fl;
    #1;
    full   = (mq.size() == 4);
    g0     = !full && !fl && v0 && (!v1 || pref == 1'b0);
    g1     = !full && !fl && v1 && (!v0 || pref == 1'b1);
    do_pop = (mq.size() != 0) && acc && !fl;
    check("req0_accept", 64'(req0_accept_o), 64'(g0));
    check("req1_accept", 64'(req1_accept_o), 64'(g1));
    check("count", 64'(count_o), 64'(mq.size()));
    check("full", 64'(full_o), 64'(full));
    check("empty", 64'(empty_o), 64'(mq.size() == 0));
    check("out_valid", 64'(out_valid_o), 64'(mq.size() != 0));
    if (mq.size() != 0) begin
      check("out_data", 64'(out_data_o), 64'(mq[0][31:0]));
      check("out_src", 64'(out_src_o), 64'(mq[0][32]));
    end
    last_a0 = req0_accept_o;
    last_a1 = req1_accept_o;
    if (do_pop) popped.push_back(out_data_o);
    @(posedge clk_i);
    if (fl) model_clear();
    else begin
      if (do_pop) void'(mq.pop_front());
      if (g0) begin mq.push_back({1'b0, d0}); pref = 1'b1; end
      if (g1) begin mq.push_back({1'b1, d1}); pref = 1'b0; end
    end
    @(negedge clk_i);
  endtask

  initial begin
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;

    // Idle after reset.
    step(0, 0, 0, 0, 0, 0);
    check("idle_acc0", 64'(last_a0), 64'd0);
    check("idle_acc1", 64'(last_a1), 64'd0);

    // Both valid, no pop: alternation, then full.
    for (int i = 0; i < 5; i++) begin
      step(1, 32'hA0, 1, 32'hB0, 0, 0);
      if (i < 4) begin
        check("alt_acc0", 64'(last_a0), 64'(i % 2 == 0));
        check("alt_acc1", 64'(last_a1), 64'(i % 2 == 1));
      end else check("full_blocks", 64'({last_a0, last_a1}), 64'd0);
    end
    check("full_after4", 64'(full_o), 64'd1);
    for (int i = 0; i < 4; i++) begin
      check("pop_src", 64'(out_src_o), 64'(i % 2));
      step(0, 0, 0, 0, 1, 0);
    end

    // Fill to 4, then pop with req0 valid: 4 -> 3, then steady at 3.
    for (int i = 0; i < 4; i++) step(1, 32'(i), 0, 0, 0, 0);
    step(1, 32'h10, 0, 0, 1, 0);
    check("pop_no_push", 64'(count_o), 64'd3);
    for (int i = 0; i < 3; i++) step(1, 32'(32'h11 + i), 0, 0, 1, 0);
    check("push_pop_hold", 64'(count_o), 64'd3);
    while (mq.size() != 0) step(0, 0, 0, 0, 1, 0);

    // Flush with 3 entries and req1 valid.
    for (int i = 0; i < 3; i++) step(1, 32'(32'h20 + i), 0, 0, 0, 0);
    step(0, 0, 1, 32'h77, 0, 1);
    check("flush_acc1", 64'(last_a1), 64'd0);
    check("flush_empty", 64'(empty_o), 64'd1);
    step(0, 0, 1, 32'h5A5A, 0, 0);
    check("flush_newdata", 64'(out_data_o), 64'h5A5A);
    step(0, 0, 0, 0, 1, 0);

    // Wrap-around ordering.
    popped.delete();
    for (int i = 0; i < 10; i++) step(1, 32'(i), 0, 0, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    check("wrap_count", 64'(popped.size()), 64'd10);
    for (int i = 0; i < 10 && i < popped.size(); i++) check("wrap_order", 64'(popped[i]), 64'(i));

    // Async reset mid-cycle with count=2, preference left on req1.
    step(1, 32'h31, 0, 0, 0, 0);
    step(1, 32'h32, 0, 0, 0, 0);
    #2 rst_i = 1'b1;
    #1;
    check("rst_count", 64'(count_o), 64'd0);
    check("rst_valid", 64'(out_valid_o), 64'd0);
    check("rst_empty", 64'(empty_o), 64'd1);
    model_clear();
    @(negedge clk_i);
    rst_i = 1'b0;
    step(1, 32'h41, 1, 32'h42, 0, 0);
    check("rst_tie_req0", 64'({last_a0, last_a1}), 64'b10);
    step(0, 0, 0, 0, 1, 0);

    // Randomized traffic with occasional flushes.
    for (int i = 0; i < 400; i++)
      step(1'($urandom), $urandom, 1'($urandom), $urandom,
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 24) == 0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule

// File: doc/dcache_axi_req_arb.md
Name: dcache_axi_req_arb

Overview:
- Shares one outstanding-request FIFO between two requesters in the dcache AXI path: refill (req0) and writeback (req1).
- Round-robin arbitration selects at most one push per cycle.
- The FIFO holds 2^ADDR_W descriptors. Each entry is tagged with the index of the requester that pushed it, and entries drain in order to the AXI issue stage.
- A synchronous local flush clears the FIFO independently of the global asynchronous reset, and either one fully clears pointers and count.

Parameters:
- ADDR_W, 2: FIFO address width; DEPTH = 2^ADDR_W entries.
- DATA_W, 32: descriptor width per requester.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  global reset, asynchronous, active-high
- flush_i  in  1  synchronous local clear (soft reset from parent)
- req0_valid_i  in  1  refill request valid
- req0_data_i  in  DATA_W  refill descriptor
- req0_accept_o  out  1  refill descriptor pushed this cycle
- req1_valid_i  in  1  writeback request valid
- req1_data_i  in  DATA_W  writeback descriptor
- req1_accept_o  out  1  writeback descriptor pushed this cycle
- out_valid_o  out  1  head entry valid
- out_data_o  out  DATA_W  head descriptor
- out_src_o  out  1  head entry requester index (0/1)
- out_accept_i  in  1  downstream pops head
- count_o  out  ADDR_W+1  occupancy
- full_o  out  1  count_o == DEPTH
- empty_o  out  1  count_o == 0

Behaviour:
- Registered state: rd_ptr_q, wr_ptr_q (ADDR_W bits), count_q (ADDR_W+1 bits), prio_q (1 bit), storage array of DEPTH x (DATA_W+1).
- Reset (rst_i high, async):
  - rd_ptr_q, wr_ptr_q, count_q, prio_q all 0.
  - out_valid_o=0, empty_o=1, full_o=0, count_o=0, accept outputs 0.
  - Storage contents are not reset.
- flush_i (sync, rst_i low):
  - Same clears as reset, on the clock edge.
  - During a flush cycle, accept outputs are forced 0 and pops are ignored.
  - flush_i and rst_i are independent; either alone fully clears the state. Asserting both is equivalent to reset.
- Arbitration (combinational, only when ~full_o && ~flush_i):
  - Only one requester valid: grant it.
  - Both valid: grant req0 if prio_q=0, else req1.
  - On a grant to requester N, prio_q <= ~N at the edge.
  - With no grant, prio_q holds.
- Push: reqN_accept_o=1 for the granted requester.
  - Writes {N, reqN_data_i} at wr_ptr_q.
  - wr_ptr_q increments and wraps modulo DEPTH.
  - Push uses the registered full_o. A pop in the same cycle does not free a slot for that cycle's push.
- Pop: occurs when out_valid_o && out_accept_i && ~flush_i.
  - rd_ptr_q increments and wraps modulo DEPTH.
  - out_accept_i while empty has no effect.
- Count: push only: +1. Pop only: -1. Push and pop together: unchanged. Count never exceeds DEPTH and never underflows.
- Output: out_valid_o = ~empty_o. out_data_o and out_src_o show the entry at rd_ptr_q. Zero-cycle latency from head to output; a pushed entry is visible on the cycle after its push.
- Accept outputs are combinational from the valids, prio_q, full_o and flush_i. They do not depend on out_accept_i.
- Reset asserted mid-burst: immediate async clear. Partial pushes are lost and requesters must re-present.

Test Plan:
- Reset, then idle: count_o=0, empty_o=1, out_valid_o=0, req0_accept_o=req1_accept_o=0 with no valids.
- Both valid continuously with data 0xA0/0xB0, no pop:
  - Accepts alternate req0, req1, req0, req1.
  - full_o=1 after 4 cycles and accepts then 0.
  - Pops return src 0,1,0,1 in order.
- Fill to 4, then hold out_accept_i=1 with req0 valid:
  - Cycle 1 pops without a push, so count goes 4 to 3.
  - Afterwards push and pop occur together and count stays at 3.
- Push 3 entries, assert flush_i for 1 cycle with req1 valid:
  - req1_accept_o=0 during the flush.
  - Next cycle count_o=0 and empty_o=1.
  - Pointers restart and the next push appears with out_data_o equal to the new data.
- Wrap-around: 10 push/pop pairs with incrementing data 0..9 → output order 0..9 with no gaps.
- Assert rst_i asynchronously mid-cycle with count=2 → outputs cleared before the next edge and prio_q=0, so req0 wins the first tie after release.
